// File: rtl/bus_cmd_controller.sv
// bus_cmd_controller
//   Processor-side bus sequencer. Accepts decoded transfer commands, drives
//   one-cycle address phases (SRC then DST) with write strobes, hands block
//   transfers to the DMA engine through dma_grant/dma_done, and services level
//   interrupt requests with fixed or round-robin priority.
//
//   Handshake: a command is transferred on a rising clock edge where
//   cmd_valid & cmd_ready are both 1. cmd_ready is registered and is 1 only
//   while the sequencer sits in IDLE and busybus was 0 at the previous edge;
//   cmd_valid must hold its fields stable until that edge.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_op/type/count       decoded command; cmd_src/cmd_dst its addresses
//   busybus                 another master owns the bus (blocks new work)
//   irq/irq_addr/irq_ack    interrupt request, data slot, one-hot acknowledge
//   dma_grant/dma_done      block-transfer handoff to the DMA engine
//   bus_addr/bus_addr_valid address phase (address is 0 when not valid)
//   io_write/mem_write      one-hot I/O write strobe, memory write strobe
//   err                     one-cycle pulse on illegal command / bad I/O address
//   dbg_state               current FSM state encoding
module bus_cmd_controller #(
    parameter int ADDR_W  = 8,
    parameter int N_IO    = 2,
    parameter int IO_BASE = 192,
    parameter int IO_WIN  = 32,
    parameter int RR_MODE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_type,
    input  logic [5:0]        cmd_count,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              busybus,
    input  logic [N_IO-1:0]   irq,
    input  logic [ADDR_W-1:0] irq_addr,
    output logic [N_IO-1:0]   irq_ack,
    output logic              dma_grant,
    input  logic              dma_done,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_addr_valid,
    output logic [N_IO-1:0]   io_write,
    output logic              mem_write,
    output logic              err,
    output logic [2:0]        dbg_state
);

    localparam int IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SRC  = 3'd1,
        S_DST  = 3'd2,
        S_DMA  = 3'd3,
        S_ACK  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        logic [31:0] a32;
        a32 = 32'(a);
        return (a32 >= 32'(IO_BASE)) && (a32 < 32'(IO_BASE + N_IO * IO_WIN));
    endfunction

    // Only meaningful when is_io(a) holds.
    function automatic logic [IDX_W-1:0] io_idx(input logic [ADDR_W-1:0] a);
        logic [31:0] off;
        off = 32'(a) - 32'(IO_BASE);
        return IDX_W'(off / 32'(IO_WIN));
    endfunction

    function automatic logic [N_IO-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_IO-1:0] v;
        v = '0;
        for (int k = 0; k < N_IO; k++) begin
            if (i == IDX_W'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, irq_addr_q, irq_addr_d;
    logic              has_dst_q, has_dst_d;
    logic              dst_io_q, dst_io_d;
    logic              dst_bad_q, dst_bad_d;
    logic [IDX_W-1:0]  ack_idx_q, ack_idx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_addr_valid_q, bus_addr_valid_d;
    logic [N_IO-1:0]   io_write_q, io_write_d;
    logic              mem_write_q, mem_write_d;
    logic              err_q, err_d;
    logic              dma_grant_q, dma_grant_d;
    logic [N_IO-1:0]   irq_ack_q, irq_ack_d;

    logic              accept;
    logic              irq_take;
    logic              plan_has_src, plan_has_dst, plan_src_io, plan_dst_io, plan_illegal;
    logic              plan_src_bad, plan_dst_bad;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx, cand;

    // Single-word sequence plan for bus ops, keyed by {op[0], type}.
    always_comb begin
        plan_has_src = 1'b0;
        plan_has_dst = 1'b0;
        plan_src_io  = 1'b0;
        plan_dst_io  = 1'b0;
        plan_illegal = 1'b0;
        case ({cmd_op[0], cmd_type})
            3'b0_00: plan_has_dst = 1'b1;
            3'b1_00: plan_has_src = 1'b1;
            3'b0_01: begin plan_has_src = 1'b1; plan_src_io = 1'b1; plan_has_dst = 1'b1; end
            3'b1_01: begin plan_has_src = 1'b1; plan_has_dst = 1'b1; plan_dst_io = 1'b1; end
            3'b1_10: begin plan_has_src = 1'b1; plan_has_dst = 1'b1; end
            3'b0_11: begin plan_has_dst = 1'b1; plan_dst_io = 1'b1; end
            3'b1_11: begin plan_has_src = 1'b1; plan_src_io = 1'b1; end
            default: plan_illegal = 1'b1;
        endcase
        plan_src_bad = plan_src_io && !is_io(cmd_src);
        plan_dst_bad = plan_dst_io && !is_io(cmd_dst);
    end

    // Interrupt winner: scan starts at the RR pointer in round-robin mode,
    // at index 0 in fixed mode; the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_IO; i++) begin
            if (RR_MODE != 0) cand = IDX_W'((int'(rr_ptr_q) + i) % N_IO);
            else              cand = IDX_W'(i);
            if (!win_found && irq[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // A presented command holds off interrupts even in the cycle where
    // cmd_ready is still catching up after busybus drops.
    always_comb begin
        accept   = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
        irq_take = (state_q == S_IDLE) && !cmd_valid && !busybus && win_found;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op[1])                state_d = S_IDLE;
                    else if (cmd_count != 6'd0)   state_d = (cmd_type == 2'b01 || cmd_type == 2'b10)
                                                            ? S_DMA : S_ERR;
                    else if (plan_illegal)        state_d = S_ERR;
                    else if (plan_has_src)        state_d = plan_src_bad ? S_ERR : S_SRC;
                    else                          state_d = plan_dst_bad ? S_ERR : S_DST;
                end else if (irq_take) begin
                    state_d = S_ACK;
                end
            end
            S_SRC: begin
                if (has_dst_q) state_d = dst_bad_q ? S_ERR : S_DST;
                else           state_d = S_IDLE;
            end
            S_DMA:   if (dma_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command / interrupt context captured at the entry edge.
    always_comb begin
        src_d      = accept ? cmd_src      : src_q;
        dst_d      = accept ? cmd_dst      : dst_q;
        has_dst_d  = accept ? plan_has_dst : has_dst_q;
        dst_io_d   = accept ? plan_dst_io  : dst_io_q;
        dst_bad_d  = accept ? plan_dst_bad : dst_bad_q;
        irq_addr_d = irq_take ? irq_addr : irq_addr_q;
        ack_idx_d  = irq_take ? win_idx  : ack_idx_q;
        rr_ptr_d   = irq_take ? IDX_W'((int'(win_idx) + 1) % N_IO) : rr_ptr_q;
    end

    // Outputs are a function of the state being entered, so the registered
    // outputs line up with the state register.
    always_comb begin
        cmd_ready_d      = 1'b0;
        bus_addr_d       = '0;
        bus_addr_valid_d = 1'b0;
        io_write_d       = '0;
        mem_write_d      = 1'b0;
        err_d            = 1'b0;
        dma_grant_d      = 1'b0;
        irq_ack_d        = '0;
        case (state_d)
            S_IDLE: cmd_ready_d = !busybus;
            S_SRC: begin
                bus_addr_d       = src_d;
                bus_addr_valid_d = 1'b1;
            end
            S_DST: begin
                bus_addr_d       = dst_d;
                bus_addr_valid_d = 1'b1;
                if (dst_io_d) io_write_d  = onehot(io_idx(dst_d));
                else          mem_write_d = 1'b1;
            end
            S_DMA: dma_grant_d = 1'b1;
            S_ACK: begin
                bus_addr_d       = irq_addr_d;
                bus_addr_valid_d = 1'b1;
                mem_write_d      = 1'b1;
                irq_ack_d        = onehot(ack_idx_d);
            end
            S_ERR:   err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= S_IDLE;
            src_q            <= '0;
            dst_q            <= '0;
            has_dst_q        <= 1'b0;
            dst_io_q         <= 1'b0;
            dst_bad_q        <= 1'b0;
            irq_addr_q       <= '0;
            ack_idx_q        <= '0;
            rr_ptr_q         <= '0;
            cmd_ready_q      <= 1'b0;
            bus_addr_q       <= '0;
            bus_addr_valid_q <= 1'b0;
            io_write_q       <= '0;
            mem_write_q      <= 1'b0;
            err_q            <= 1'b0;
            dma_grant_q      <= 1'b0;
            irq_ack_q        <= '0;
        end else begin
            state_q          <= state_d;
            src_q            <= src_d;
            dst_q            <= dst_d;
            has_dst_q        <= has_dst_d;
            dst_io_q         <= dst_io_d;
            dst_bad_q        <= dst_bad_d;
            irq_addr_q       <= irq_addr_d;
            ack_idx_q        <= ack_idx_d;
            rr_ptr_q         <= rr_ptr_d;
            cmd_ready_q      <= cmd_ready_d;
            bus_addr_q       <= bus_addr_d;
            bus_addr_valid_q <= bus_addr_valid_d;
            io_write_q       <= io_write_d;
            mem_write_q      <= mem_write_d;
            err_q            <= err_d;
            dma_grant_q      <= dma_grant_d;
            irq_ack_q        <= irq_ack_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign bus_addr       = bus_addr_q;
    assign bus_addr_valid = bus_addr_valid_q;
    assign io_write       = io_write_q;
    assign mem_write      = mem_write_q;
    assign err            = err_q;
    assign dma_grant      = dma_grant_q;
    assign irq_ack        = irq_ack_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_bus_cmd_controller.sv
// Bench for bus_cmd_controller. Two instances share all inputs: one in fixed
// priority mode, one in round-robin mode. Each driven cycle pushes the
// expected outputs of both instances for the coming edge; a monitor pops and
// compares one entry per edge.
module tb_bus_cmd_controller;

    localparam int OW = 17;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op, cmd_type;
    logic [5:0] cmd_count;
    logic [7:0] cmd_src, cmd_dst;
    logic       busybus;
    logic [1:0] irq;
    logic [7:0] irq_addr;
    logic       dma_done;

    logic       cmd_ready_f, bus_addr_valid_f, mem_write_f, err_f, dma_grant_f;
    logic [7:0] bus_addr_f;
    logic [1:0] io_write_f, irq_ack_f;
    logic [2:0] dbg_f;
    logic       cmd_ready_r, bus_addr_valid_r, mem_write_r, err_r, dma_grant_r;
    logic [7:0] bus_addr_r;
    logic [1:0] io_write_r, irq_ack_r;
    logic [2:0] dbg_r;

    logic [2*OW-1:0] exp_q[$];
    string           tag_q[$];
    string           cur_tag;
    int              n_checks = 0;
    int              n_errors = 0;

    always #5 clk = ~clk;

    bus_cmd_controller #(.ADDR_W(8), .N_IO(2), .IO_BASE(192), .IO_WIN(32), .RR_MODE(0)) dut (
        .clock(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_f),
        .cmd_op(cmd_op), .cmd_type(cmd_type), .cmd_count(cmd_count),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .busybus(busybus),
        .irq(irq), .irq_addr(irq_addr), .irq_ack(irq_ack_f),
        .dma_grant(dma_grant_f), .dma_done(dma_done),
        .bus_addr(bus_addr_f), .bus_addr_valid(bus_addr_valid_f),
        .io_write(io_write_f), .mem_write(mem_write_f), .err(err_f), .dbg_state(dbg_f)
    );

    bus_cmd_controller #(.ADDR_W(8), .N_IO(2), .IO_BASE(192), .IO_WIN(32), .RR_MODE(1)) dut_rr (
        .clock(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_r),
        .cmd_op(cmd_op), .cmd_type(cmd_type), .cmd_count(cmd_count),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .busybus(busybus),
        .irq(irq), .irq_addr(irq_addr), .irq_ack(irq_ack_r),
        .dma_grant(dma_grant_r), .dma_done(dma_done),
        .bus_addr(bus_addr_r), .bus_addr_valid(bus_addr_valid_r),
        .io_write(io_write_r), .mem_write(mem_write_r), .err(err_r), .dbg_state(dbg_r)
    );

    logic [OW-1:0] out_f, out_r;
    assign out_f = {cmd_ready_f, bus_addr_valid_f, bus_addr_f, io_write_f,
                    mem_write_f, err_f, dma_grant_f, irq_ack_f};
    assign out_r = {cmd_ready_r, bus_addr_valid_r, bus_addr_r, io_write_r,
                    mem_write_r, err_r, dma_grant_r, irq_ack_r};

    // Expected-output builders: {cmd_ready, valid, addr, io_write, mem_write, err, grant, ack}
    function automatic logic [OW-1:0] o(input logic cr, input logic v, input logic [7:0] a,
                                        input logic [1:0] iow, input logic mw, input logic er,
                                        input logic g, input logic [1:0] ack);
        return {cr, v, a, iow, mw, er, g, ack};
    endfunction
    function automatic logic [OW-1:0] o_zero();             return '0;                          endfunction
    function automatic logic [OW-1:0] o_idle();             return o(1, 0, 8'h00, 2'b00, 0, 0, 0, 2'b00); endfunction
    function automatic logic [OW-1:0] o_src(input logic [7:0] a);  return o(0, 1, a, 2'b00, 0, 0, 0, 2'b00); endfunction
    function automatic logic [OW-1:0] o_dmem(input logic [7:0] a); return o(0, 1, a, 2'b00, 1, 0, 0, 2'b00); endfunction
    function automatic logic [OW-1:0] o_dio(input logic [7:0] a, input logic [1:0] w);
        return o(0, 1, a, w, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [OW-1:0] o_err();              return o(0, 0, 8'h00, 2'b00, 0, 1, 0, 2'b00); endfunction
    function automatic logic [OW-1:0] o_gnt();              return o(0, 0, 8'h00, 2'b00, 0, 0, 1, 2'b00); endfunction
    function automatic logic [OW-1:0] o_ack(input logic [7:0] a, input logic [1:0] k);
        return o(0, 1, a, 2'b00, 1, 0, 0, k);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Push expectations for the next edge, then advance to the following negedge.
    task automatic tick(input logic [OW-1:0] ef, input logic [OW-1:0] er);
        exp_q.push_back({ef, er});
        tag_q.push_back(cur_tag);
        @(negedge clk);
    endtask

    task automatic tick1(input logic [OW-1:0] e);
        tick(e, e);
    endtask

    // Present one command for a single accept edge, then expect up to two
    // phases and a return to IDLE.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] typ,
                           input logic [5:0] cnt, input logic [7:0] src, input logic [7:0] dst,
                           input int n, input logic [OW-1:0] e0, input logic [OW-1:0] e1);
        cur_tag   = tag;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_type  = typ;
        cmd_count = cnt;
        cmd_src   = src;
        cmd_dst   = dst;
        tick1(e0);
        cmd_valid = 1'b0;
        if (n > 1) tick1(e1);
        tick1(o_idle());
    endtask

    always @(posedge clk) begin
        logic [2*OW-1:0] e;
        string           t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "/fixed"}, 32'(out_f), 32'(e[2*OW-1:OW]));
            check({t, "/rr"},    32'(out_r), 32'(e[OW-1:0]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_type  = 2'b00;
        cmd_count = 6'd0;
        cmd_src   = 8'h00;
        cmd_dst   = 8'h33;
        busybus   = 1'b0;
        irq       = 2'b00;
        irq_addr  = 8'h20;
        dma_done  = 1'b0;

        // Reset with a command presented: everything low, no accept.
        cur_tag = "reset";
        tick1(o_zero());
        tick1(o_zero());
        reset = 1'b0;
        cur_tag = "ready_after_reset";
        tick1(o_idle());
        cur_tag = "first_cmd_dst_mem";
        tick1(o_dmem(8'h33));
        cmd_valid = 1'b0;
        tick1(o_idle());

        // Single-word sequences.
        run_cmd("ld_mem_io",      2'b01, 2'b01, 6'd0, 8'h10, 8'hE4, 2, o_src(8'h10), o_dio(8'hE4, 2'b10));
        run_cmd("st_reg_io_bad",  2'b00, 2'b11, 6'd0, 8'h00, 8'h40, 1, o_err(), o_zero());
        run_cmd("st_mem_io_bad",  2'b00, 2'b01, 6'd0, 8'h10, 8'h22, 1, o_err(), o_zero());
        run_cmd("st_mem_io",      2'b00, 2'b01, 6'd0, 8'hC5, 8'h22, 2, o_src(8'hC5), o_dmem(8'h22));
        run_cmd("ld_mem_io_bad",  2'b01, 2'b01, 6'd0, 8'h10, 8'h80, 2, o_src(8'h10), o_err());
        run_cmd("ld_reg_io",      2'b01, 2'b11, 6'd0, 8'hE0, 8'h00, 1, o_src(8'hE0), o_zero());
        run_cmd("ld_reg_io_bad",  2'b01, 2'b11, 6'd0, 8'h7F, 8'h00, 1, o_err(), o_zero());
        run_cmd("io_edge_DF",     2'b00, 2'b11, 6'd0, 8'h00, 8'hDF, 1, o_dio(8'hDF, 2'b01), o_zero());
        run_cmd("io_edge_FF",     2'b00, 2'b11, 6'd0, 8'h00, 8'hFF, 1, o_dio(8'hFF, 2'b10), o_zero());
        run_cmd("io_edge_C0",     2'b00, 2'b11, 6'd0, 8'h00, 8'hC0, 1, o_dio(8'hC0, 2'b01), o_zero());
        run_cmd("io_edge_BF",     2'b00, 2'b11, 6'd0, 8'h00, 8'hBF, 1, o_err(), o_zero());
        run_cmd("illegal_mm_st",  2'b00, 2'b10, 6'd0, 8'h01, 8'h02, 1, o_err(), o_zero());
        run_cmd("dma_bad_type",   2'b00, 2'b00, 6'd3, 8'h01, 8'h02, 1, o_err(), o_zero());
        run_cmd("alu_no_bus",     2'b10, 2'b10, 6'd0, 8'h01, 8'h02, 1, o_idle(), o_zero());
        run_cmd("ld_mem_mem",     2'b01, 2'b10, 6'd0, 8'h12, 8'h34, 2, o_src(8'h12), o_dmem(8'h34));
        run_cmd("ld_reg_mem",     2'b01, 2'b00, 6'd0, 8'h55, 8'h00, 1, o_src(8'h55), o_zero());

        // DMA block, done pulsed four cycles after accept.
        cur_tag   = "dma_block";
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_type = 2'b10; cmd_count = 6'd5;
        cmd_src   = 8'h12; cmd_dst = 8'h34;
        tick1(o_gnt());
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick1(o_gnt());
        dma_done = 1'b1;
        cur_tag  = "dma_release";
        tick1(o_idle());
        dma_done = 1'b0;
        tick1(o_idle());

        // Shortest DMA: done seen on the first grant cycle.
        cur_tag   = "dma_short";
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_type = 2'b10; cmd_count = 6'd1;
        tick1(o_gnt());
        cmd_valid = 1'b0;
        dma_done  = 1'b1;
        tick1(o_idle());
        dma_done  = 1'b0;

        // Interrupts held on both lines.
        cur_tag  = "irq_alternate";
        irq      = 2'b11;
        irq_addr = 8'h20;
        tick(o_ack(8'h20, 2'b01), o_ack(8'h20, 2'b01));
        tick1(o_idle());
        tick(o_ack(8'h20, 2'b01), o_ack(8'h20, 2'b10));
        tick1(o_idle());
        tick(o_ack(8'h20, 2'b01), o_ack(8'h20, 2'b01));
        irq = 2'b00;
        tick1(o_idle());

        // Command and interrupt together: command first.
        cur_tag   = "cmd_before_irq";
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_type = 2'b00; cmd_count = 6'd0; cmd_src = 8'h77;
        irq       = 2'b10;
        irq_addr  = 8'h31;
        tick1(o_src(8'h77));
        cmd_valid = 1'b0;
        tick1(o_idle());
        cur_tag = "irq_after_cmd";
        tick1(o_ack(8'h31, 2'b10));
        irq = 2'b00;
        tick1(o_idle());

        // busybus blocks both commands and interrupts.
        cur_tag = "busy_drop_ready";
        busybus = 1'b1;
        tick1(o_zero());
        cur_tag   = "busy_hold";
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_type = 2'b00; cmd_dst = 8'h44;
        irq       = 2'b01;
        tick1(o_zero());
        tick1(o_zero());
        busybus = 1'b0;
        cur_tag = "busy_release";
        tick1(o_idle());
        tick1(o_dmem(8'h44));
        cmd_valid = 1'b0;
        tick1(o_idle());
        cur_tag = "busy_irq";
        tick1(o_ack(8'h31, 2'b01));
        irq = 2'b00;
        tick1(o_idle());

        // Reset abandons a DMA block; grant drops at the reset edge.
        cur_tag   = "reset_mid_dma";
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_type = 2'b01; cmd_count = 6'd3;
        tick1(o_gnt());
        cmd_valid = 1'b0;
        tick1(o_gnt());
        reset = 1'b1;
        tick1(o_zero());
        reset = 1'b0;
        tick1(o_idle());

        @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_cmd_controller.md
Name: bus_cmd_controller

Overview:
Parametrised processor-side bus sequencer for the DMA system. Accepts decoded transfer commands and drives address phases plus write strobes on the shared bus. Hands multi-word transfers to the DMA engine via a grant/done handshake. Services I/O interrupt requests, with fixed or round-robin priority across N_IO devices. Replaces delay-based address sequencing with a clocked state machine.

Parameters:
ADDR_W, 8, bus address width
N_IO, 2, number of I/O devices (1..8)
IO_BASE, 192, first I/O address
IO_WIN, 32, addresses per I/O device; power of two
RR_MODE, 0, interrupt priority: 0 = fixed (lowest index wins), 1 = round-robin

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 store-to-dst, 01 load-from-src, 10/11 ALU (no bus)
cmd_type  in  2  00 reg-mem, 01 mem-io, 10 mem-mem, 11 reg-io
cmd_count  in  6  0 = single word; nonzero = DMA block
cmd_src  in  ADDR_W  source address
cmd_dst  in  ADDR_W  destination address
busybus  in  1  bus owned by another master
irq  in  N_IO  interrupt request per device (level)
irq_addr  in  ADDR_W  first empty memory slot for interrupt data
irq_ack  out  N_IO  one-hot interrupt acknowledge
dma_grant  out  1  bus granted to DMA
dma_done  in  1  DMA finished block
bus_addr  out  ADDR_W  address phase; 0 when bus_addr_valid = 0
bus_addr_valid  out  1  bus_addr meaningful
io_write  out  N_IO  one-hot I/O write strobe
mem_write  out  1  memory write strobe
err  out  1  one-cycle pulse: illegal command or undecodable I/O address

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0 at the next edge, including cmd_ready, dma_grant, irq_ack, strobes, err. RR pointer = 0. Reset mid-transfer or mid-DMA abandons it; dma_grant drops at the same edge.
- All outputs are registered.
- States: IDLE, SRC, DST, DMA, ACK, ERR.
- cmd_ready = 1 only in IDLE with busybus = 0. Commands take priority over interrupts.
- I/O decode: an address is I/O when IO_BASE <= a < IO_BASE + N_IO*IO_WIN. Index = (a - IO_BASE) / IO_WIN. Everything else is memory.
- On accept with count = 0, the sequence is chosen by (op, type):
  - 00/00: DST with mem_write.
  - 01/00: SRC.
  - 00/01: SRC, then DST with mem_write; src must be I/O.
  - 01/01: SRC, then DST with io_write[idx(dst)]; dst must be I/O.
  - 01/10: SRC, then DST with mem_write.
  - 00/11: DST with io_write[idx(dst)].
  - 01/11: SRC; src must be I/O.
  - 00/10: illegal; goes to ERR.
- SRC phase: bus_addr = src, valid = 1, no strobes. DST phase: bus_addr = dst, valid = 1, strobe as listed.
- Each phase lasts exactly one cycle. The first phase is visible the cycle after accept. Return to IDLE follows the last phase.
- I/O-required address fails decode: go to ERR instead of the phase. ERR lasts one cycle with err = 1 and no strobes, then IDLE.
- count != 0 with type 01 or 10 (op 00 or 01): enter DMA. dma_grant = 1 from the next cycle until the cycle after dma_done is sampled high, then IDLE. Bus outputs idle throughout.
- count != 0 with type 00 or 11: ERR.
- op 10/11: accepted, no bus activity, stays IDLE.
- Interrupts: checked in IDLE when no command is accepted that cycle, busybus = 0, and |irq.
  - Winner: fixed mode takes the lowest set index. RR mode takes the first set index at or after the pointer, wrapping.
  - ACK state, one cycle: irq_ack[winner] = 1, bus_addr = irq_addr (captured at entry), mem_write = 1.
  - RR pointer becomes winner+1 mod N_IO.
- Neither busybus nor a new cmd_valid affects an in-progress sequence. Only reset does.

Test Plan:
- Reset held 2 cycles with cmd_valid = 1 -> all outputs 0 and cmd_ready = 0. First cycle after release: cmd_ready = 1.
- op 01, type 01, src 0x10, dst 0xE4, count 0 -> cycle +1: bus_addr 0x10, no strobe. Cycle +2: bus_addr 0xE4, io_write = 2'b10. Cycle +3: idle.
- op 00, type 11, dst 0x40 -> err pulse one cycle, no io_write, back to IDLE with cmd_ready = 1.
- op 01, type 10, count 5; dma_done pulsed 4 cycles later -> dma_grant high 4 cycles, low the cycle after dma_done, cmd_ready then 1.
- irq = 2'b11 held, no commands, RR_MODE = 1, irq_addr 0x20 -> acks alternate 01, 10, 01, each with bus_addr 0x20 and mem_write = 1. With RR_MODE = 0, ack is always 01.
- Command and irq arrive together with busybus = 0 -> command sequence runs first, ACK follows. busybus = 1 -> neither starts until it drops.
